// File: rtl/csc_column_walker_if.sv
// Handshake and spad-side signals of the CSC column walker.
// The walker uses the slave modport; a driver or testbench uses the master modport.
interface csc_column_walker_if;
  logic       start;
  logic [7:0] addr_data;
  logic       addr_index_inc;
  logic       elem_valid;
  logic       elem_ready;
  logic [7:0] data_index;
  logic [3:0] col_id;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  start,
    input  addr_data,
    input  elem_ready,
    output addr_index_inc,
    output elem_valid,
    output data_index,
    output col_id,
    output busy,
    output done,
    output err
  );

  modport master (
    output start,
    output addr_data,
    output elem_ready,
    input  addr_index_inc,
    input  elem_valid,
    input  data_index,
    input  col_id,
    input  busy,
    input  done,
    input  err
  );
endinterface

// File: rtl/csc_column_walker.sv
// Walks the column end pointers of a CSC matrix and emits one data-spad index per nonzero
// element, tagged with its column number.
module csc_column_walker (
  input  logic                  clock,
  input  logic                  reset,
  csc_column_walker_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  state_e     state_q;
  logic [7:0] data_index_q;
  logic [7:0] end_ptr_q;
  logic [3:0] col_id_q;
  logic       err_q;

  logic [8:0] idx_inc;
  logic       last_elem;
  logic       emit_hs;
  logic       fetch_adv;
  logic [3:0] col_next;

  always_comb begin
    idx_inc   = {1'b0, data_index_q} + 9'd1;
    last_elem = (idx_inc == {1'b0, end_ptr_q});
    emit_hs   = (state_q == StEmit) && bus.elem_ready;
    // End sign (0), empty column and backwards pointer all consume the address entry.
    fetch_adv = (state_q == StFetch) && (bus.addr_data <= data_index_q);
    col_next  = (col_id_q == 4'hF) ? col_id_q : col_id_q + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      data_index_q <= 8'd0;
      end_ptr_q    <= 8'd0;
      col_id_q     <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            data_index_q <= 8'd0;
            col_id_q     <= 4'd0;
            err_q        <= 1'b0;
            state_q      <= StFetch;
          end
        end
        StFetch: begin
          if (bus.addr_data == 8'd0) begin
            state_q <= StDone;
          end else if (bus.addr_data <= data_index_q) begin
            col_id_q <= col_next;
            if (bus.addr_data < data_index_q) err_q <= 1'b1;
          end else begin
            end_ptr_q <= bus.addr_data;
            state_q   <= StEmit;
          end
        end
        StEmit: begin
          if (bus.elem_ready) begin
            data_index_q <= idx_inc[7:0];
            if (last_elem) begin
              col_id_q <= col_next;
              state_q  <= StFetch;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Gated by reset so the spad pointer never moves while the block is held in reset.
  assign bus.addr_index_inc = reset && (fetch_adv || (emit_hs && last_elem));
  assign bus.elem_valid     = (state_q == StEmit);
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = (state_q == StDone);
  assign bus.data_index     = data_index_q;
  assign bus.col_id         = col_id_q;
  assign bus.err            = err_q;

endmodule

// File: doc/csc_column_walker.md
CSC_COLUMN_WALKER -- requirements
Module: csc_column_walker

Interface
REQ-001 The module SHALL provide these ports (name, direction, width, meaning):
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
- start  input  1  begin walking one CSC matrix; honoured only in IDLE
- addr_data  input  8  current former address spad output; nonzero = cumulative end pointer of the current column; 0 = end sign
- addr_index_inc  output  1  one-cycle pulse; advances the address spad read pointer
- elem_valid  output  1  a data spad read index is presented
- elem_ready  input  1  downstream accepts the index; handshake = elem_valid & elem_ready
- data_index  output  8  data spad read index of the current element
- col_id  output  4  column number of the current element
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse on walk completion
- err  output  1  sticky flag: non-monotonic end pointer detected

Function
REQ-002 The FSM SHALL have exactly four states: IDLE, FETCH, EMIT, DONE.
REQ-003 IDLE: on start==1, the block SHALL clear data_index and col_id and enter FETCH; otherwise it SHALL remain in IDLE.
REQ-004 FETCH is a single cycle; the block SHALL evaluate addr_data combinationally against data_index:
- addr_data==0 -> assert addr_index_inc (rewinds the spad) and go to DONE
- addr_data==data_index (empty column) -> assert addr_index_inc, increment col_id, stay in FETCH
- addr_data<data_index, nonzero -> set err, assert addr_index_inc, increment col_id, stay in FETCH (column skipped)
- addr_data>data_index -> register addr_data into end_ptr, no addr_index_inc, go to EMIT
REQ-005 EMIT: elem_valid SHALL be 1 and data_index and col_id SHALL be held stable until the handshake completes.
REQ-006 On an EMIT handshake, data_index SHALL increment by 1; if data_index+1==end_ptr, the block SHALL also assert addr_index_inc in that cycle, increment col_id, and go to FETCH; otherwise it SHALL remain in EMIT.
REQ-007 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-008 addr_index_inc SHALL be combinational from state and inputs, and high at most one cycle per column or end sign.
REQ-009 Number of addr_index_inc pulses per walk SHALL equal the number of address entries including the terminating 0, which leaves the spad read pointer at 0.
REQ-010 Timing: first elem_valid SHALL occur 2 cycles after start is sampled (FETCH, then EMIT). Each element SHALL take 1 cycle with elem_ready held high. Each column boundary SHALL add 1 FETCH cycle.
REQ-011 start SHALL be ignored while busy==1.
REQ-012 data_index and end_ptr SHALL be 8-bit unsigned with no wrap: end_ptr≤255 guarantees data_index≤254 while emitting.
REQ-013 col_id SHALL saturate at 15.
REQ-014 err SHALL be cleared only by reset or by a start accepted in IDLE.
REQ-015 elem_valid SHALL be 0 in IDLE, FETCH and DONE.

Reset
REQ-016 While reset==0, the next state SHALL be IDLE and all outputs SHALL be 0: busy, elem_valid, addr_index_inc, done, err, data_index, col_id (end_ptr cleared too).
REQ-017 A reset mid-walk SHALL abandon the walk without a done pulse; the address spad shares the same reset and is rewound by it, not by this block.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- V1 spad [2,3,5,0], elem_ready=1 -> (index,col) = (0,0)(1,0)(2,1)(3,2)(4,2); 4 addr_index_inc pulses; done 1 cycle; total 10 cycles from start to done.
- V2 spad [1,1,3,0] -> (0,0)(1,2)(2,2); col 1 skipped with 1 extra FETCH cycle; err stays 0.
- V3 spad [0] -> no elem_valid; 1 addr_index_inc; done 2 cycles after start.
- V4 spad [3,0], elem_ready low for 3 cycles on each element -> data_index and col_id stable while stalled; each element accepted once; done after the 3rd acceptance plus FETCH.
- V5 spad [3,2,4,0] -> elements 0,1,2 in col 0; col 1 skipped with err=1; element 3 in col 2; err stays 1 after done until next start.
- V6 reset==0 during the 2nd element of V1, with start pulsed while busy in the same run -> all outputs 0 next cycle; no done; the extra start has no effect; a later start reproduces V1 exactly.
